// File: rtl/cache_req_arbiter.sv
// Arbitrates one cache controller between instruction fetch (req 0) and data access (req 1).
// Data wins by default; a grant-streak counter forces a fetch grant and a watchdog bounds WAIT.
module cache_req_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int MAX_DGRANT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r0_addr,
    input  logic        r0_rd,
    output logic [15:0] r0_data_out,
    output logic        r0_done,
    output logic        r0_stall,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r1_data_in,
    input  logic        r1_rd,
    input  logic        r1_wr,
    output logic [15:0] r1_data_out,
    output logic        r1_done,
    output logic        r1_stall,
    output logic [15:0] c_addr,
    output logic [15:0] c_data_in,
    output logic        c_rd,
    output logic        c_wr,
    input  logic [15:0] c_data_out,
    input  logic        c_done,
    input  logic        c_err,
    output logic        err
);

    localparam int DC_W = $clog2(MAX_DGRANT + 1);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [DC_W-1:0] DC_MAX  = DC_W'(MAX_DGRANT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_addr;
    logic [15:0]       r_data;
    logic              r_op_wr;
    logic              r_owner;
    logic              r_err;
    logic [DC_W-1:0]   r_dcount;
    logic [WD_W-1:0]   r_wdog;
    logic [WD_W-1:0]   w_wdog_nxt;

    logic              w_r1_req;
    logic              w_r1_bad;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_done0;
    logic              w_done1;
    logic [15:0]       w_done_data;
    logic              w_set_err;
    logic              w_c_rd;
    logic              w_c_wr;
    logic              w_drive;

    assign w_r1_req = r1_rd | r1_wr;
    assign w_r1_bad = r1_rd & r1_wr;

    always_comb begin
        w_state_nxt = r_state;
        w_wdog_nxt  = r_wdog;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        w_done_data = '0;
        w_set_err   = c_err;
        w_c_rd      = 1'b0;
        w_c_wr      = 1'b0;
        w_drive     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (c_done) w_set_err = 1'b1;
                // A saturated streak hands the slot to a waiting fetch ahead of data.
                if (r0_rd && (r_dcount == DC_MAX)) begin
                    w_grant0    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (w_r1_bad) begin
                    w_done1   = 1'b1;
                    w_set_err = 1'b1;
                end else if (w_r1_req) begin
                    w_grant1    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (r0_rd) begin
                    w_grant0    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (c_done) w_set_err = 1'b1;
                w_c_rd      = ~r_op_wr;
                w_c_wr      = r_op_wr;
                w_drive     = 1'b1;
                w_wdog_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_drive = 1'b1;
                if (c_done) begin
                    w_done0     = ~r_owner;
                    w_done1     = r_owner;
                    w_done_data = r_op_wr ? 16'h0000 : c_data_out;
                    w_state_nxt = S_IDLE;
                end else if (r_wdog == WD_LAST) begin
                    w_done0     = ~r_owner;
                    w_done1     = r_owner;
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: begin
                w_set_err   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_data   <= '0;
            r_op_wr  <= 1'b0;
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
            r_dcount <= '0;
            r_wdog   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wdog  <= w_wdog_nxt;
            if (w_set_err) r_err <= 1'b1;
            if (w_grant0 || w_grant1) begin
                r_addr  <= w_grant1 ? r1_addr : r0_addr;
                r_data  <= w_grant1 ? r1_data_in : 16'h0000;
                r_op_wr <= w_grant1 & r1_wr;
                r_owner <= w_grant1;
            end
            if (!r0_rd || w_grant0) begin
                r_dcount <= '0;
            end else if (w_grant1 && (r_dcount != DC_MAX)) begin
                r_dcount <= r_dcount + 1'b1;
            end
        end
    end

    // Completion outputs are combinational, so hold them low while reset is asserted.
    assign r0_done     = rst & w_done0;
    assign r1_done     = rst & w_done1;
    assign r0_data_out = r0_done ? w_done_data : 16'h0000;
    assign r1_data_out = r1_done ? w_done_data : 16'h0000;
    assign r0_stall    = rst & r0_rd & ~r0_done;
    assign r1_stall    = rst & w_r1_req & ~r1_done;
    assign c_rd        = w_c_rd;
    assign c_wr        = w_c_wr;
    assign c_addr      = w_drive ? r_addr : 16'h0000;
    assign c_data_in   = w_drive ? r_data : 16'h0000;
    assign err         = r_err;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter: a transaction-level grant model predicts each issue and
// each completion; a cache-controller model answers issues; a monitor checks every done pulse.
module tb_cache_req_arbiter;
    localparam int TIMEOUT = 64;
    localparam int MAXD    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] r0_addr = '0, r1_addr = '0, r1_data_in = '0, c_data_out = '0;
    logic        r0_rd = 1'b0, r1_rd = 1'b0, r1_wr = 1'b0, c_done = 1'b0, c_err = 1'b0;
    logic [15:0] r0_data_out, r1_data_out, c_addr, c_data_in;
    logic        r0_done, r0_stall, r1_done, r1_stall, c_rd, c_wr, err;

    cache_req_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DGRANT(MAXD)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_rd(r0_rd), .r0_data_out(r0_data_out),
        .r0_done(r0_done), .r0_stall(r0_stall),
        .r1_addr(r1_addr), .r1_data_in(r1_data_in), .r1_rd(r1_rd), .r1_wr(r1_wr),
        .r1_data_out(r1_data_out), .r1_done(r1_done), .r1_stall(r1_stall),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_rd(c_rd), .c_wr(c_wr),
        .c_data_out(c_data_out), .c_done(c_done), .c_err(c_err), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { bit owner; logic [15:0] addr; logic [15:0] data; bit wr; } iss_t;
    typedef struct { bit owner; logic [15:0] data; } cmp_t;

    iss_t        iss_q[$];
    cmp_t        cmp_q[$];
    bit          owner_log[$];
    int          n_cmp = 0, n_err = 0, n_issue = 0;
    bit          m_busy = 1'b0, exp_err = 1'b0;
    int          streak = 0;
    int          ctl_mode = 0;   // 0 answer, 1 never answer (watchdog), 2 silent
    int          ctl_delay = 0;  // 0 picks a random delay
    bit          ctl_fixdata = 1'b0;
    logic [15:0] ctl_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grant rule: data first, unless a fetch has waited through MAXD data grants in a row.
    task automatic model_loop();
        bit g0, g1;
        forever begin
            @(negedge clk);
            if (!rst) continue;
            g0 = 1'b0;
            g1 = 1'b0;
            if (!m_busy) begin
                if (r0_rd && streak == MAXD) g0 = 1'b1;
                else if (r1_rd && r1_wr) begin
                    cmp_q.push_back('{1'b1, 16'h0000});
                    exp_err = 1'b1;
                end
                else if (r1_rd || r1_wr) g1 = 1'b1;
                else if (r0_rd) g0 = 1'b1;
                if (g0) begin iss_q.push_back('{1'b0, r0_addr, 16'h0000, 1'b0}); m_busy = 1'b1; end
                if (g1) begin iss_q.push_back('{1'b1, r1_addr, r1_data_in, r1_wr}); m_busy = 1'b1; end
            end
            if (!r0_rd || g0) streak = 0;
            else if (g1 && streak < MAXD) streak++;
        end
    endtask

    task automatic ctl_loop();
        iss_t        e;
        logic [15:0] rdat;
        int          d;
        forever begin
            @(negedge clk);
            if (rst && (c_rd || c_wr)) begin
                n_issue++;
                if (iss_q.size() == 0) begin
                    check("issue_expected", 32'(iss_q.size()), 1);
                    continue;
                end
                e = iss_q.pop_front();
                check("c_addr", 32'(c_addr), 32'(e.addr));
                check("c_data_in", 32'(c_data_in), 32'(e.data));
                check("c_op", 32'({c_rd, c_wr}), 32'({~e.wr, e.wr}));
                if (ctl_mode == 1) begin
                    cmp_q.push_back('{e.owner, 16'h0000});
                    exp_err = 1'b1;
                    repeat (TIMEOUT + 1) @(posedge clk);
                    #1 m_busy = 1'b0;
                end else if (ctl_mode == 0) begin
                    d    = (ctl_delay > 0) ? ctl_delay : $urandom_range(1, 5);
                    rdat = ctl_fixdata ? ctl_data : 16'($urandom);
                    cmp_q.push_back('{e.owner, e.wr ? 16'h0000 : rdat});
                    repeat (d) @(posedge clk);
                    #1 c_done = 1'b1; c_data_out = rdat;
                    @(posedge clk);
                    #1 c_done = 1'b0; c_data_out = 16'($urandom); m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic mon_loop();
        cmp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) continue;
            if (r0_done || r1_done) begin
                check("double_done", 32'(r0_done & r1_done), 0);
                if (cmp_q.size() == 0) check("done_expected", 32'(cmp_q.size()), 1);
                else begin
                    e = cmp_q.pop_front();
                    check("done_owner", 32'(r1_done), 32'(e.owner));
                    check("done_data", 32'(r1_done ? r1_data_out : r0_data_out), 32'(e.data));
                    owner_log.push_back(r1_done);
                end
            end
            if (r0_rd) check("r0_stall", 32'(r0_stall), 32'(!r0_done));
            if (r1_rd || r1_wr) check("r1_stall", 32'(r1_stall), 32'(!r1_done));
        end
    endtask

    task automatic drv0(input logic [15:0] a, output int cyc);
        r0_addr = a;
        r0_rd   = 1'b1;
        cyc     = 0;
        do begin @(negedge clk); cyc++; end while (!r0_done && cyc < 300);
        check("r0_done_seen", 32'(r0_done), 1);
        @(posedge clk);
        #1 r0_rd = 1'b0;
    endtask

    task automatic drv1(input logic [15:0] a, input logic [15:0] dat, input bit rd, input bit wr,
                        output int cyc);
        r1_addr    = a;
        r1_data_in = dat;
        r1_rd      = rd;
        r1_wr      = wr;
        cyc        = 0;
        do begin @(negedge clk); cyc++; end while (!r1_done && cyc < 300);
        check("r1_done_seen", 32'(r1_done), 1);
        @(posedge clk);
        #1 r1_rd = 1'b0; r1_wr = 1'b0;
    endtask

    task automatic rnd0(input int n, input int gapmax);
        int c;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
            drv0(16'($urandom), c);
        end
    endtask

    task automatic rnd1(input int n, input int gapmax);
        int c;
        bit w;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapmax)) begin @(posedge clk); #1; end
            w = 1'($urandom_range(0, 1));
            drv1(16'($urandom), 16'($urandom), !w, w, c);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; r0_rd = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0; c_done = 1'b0; c_err = 1'b0;
        iss_q.delete(); cmp_q.delete();
        m_busy = 1'b0; streak = 0; exp_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, c2;
        bit pat[10];
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        fork
            model_loop();
            ctl_loop();
            mon_loop();
        join_none

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_rd", 32'(c_rd), 0);
        check("rst_c_wr", 32'(c_wr), 0);
        check("rst_done", 32'({r0_done, r1_done}), 0);
        check("rst_err", 32'(err), 0);
        check("rst_c_addr", 32'(c_addr), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single fetch answered four cycles after issue with 16'hBEEF.
        ctl_delay = 4; ctl_fixdata = 1'b1; ctl_data = 16'hBEEF; n_issue = 0;
        drv0(16'h0040, c);
        check("fetch_latency", 32'(c), 6);
        check("fetch_issue_count", 32'(n_issue), 1);
        ctl_fixdata = 1'b0;
        ctl_delay = 1;
        drv0(16'h0100, c);
        check("min_latency", 32'(c), 3);
        ctl_delay = 0;

        // Simultaneous fetch and store: the store goes first.
        owner_log.delete();
        fork
            drv1(16'h1234, 16'h00FF, 1'b0, 1'b1, c);
            drv0(16'h2000, c2);
        join
        check("both_count", 32'(owner_log.size()), 2);
        check("both_first_r1", 32'(owner_log[0]), 1);
        check("both_second_r0", 32'(owner_log[1]), 0);

        // Fetch held against continuous data traffic.
        owner_log.delete();
        fork
            rnd0(2, 0);
            rnd1(8, 0);
        join
        check("starve_count", 32'(owner_log.size()), 10);
        for (int i = 0; i < 10; i++) check($sformatf("starve_order_%0d", i), 32'(owner_log[i]), 32'(pat[i]));

        // Random mixed traffic.
        fork
            rnd0(25, 3);
            rnd1(25, 3);
        join
        repeat (3) @(posedge clk);
        #1;
        check("rand_err", 32'(err), 32'(exp_err));
        check("rand_iss_empty", 32'(iss_q.size()), 0);
        check("rand_cmp_empty", 32'(cmp_q.size()), 0);

        // Load and store together is rejected.
        n_issue = 0;
        drv1(16'h0ABC, 16'h5555, 1'b1, 1'b1, c);
        check("bad_latency", 32'(c), 1);
        check("bad_no_issue", 32'(n_issue), 0);
        check("bad_err", 32'(err), 1);

        // Watchdog abort, then a normal request is still served.
        do_reset();
        check("err_cleared", 32'(err), 0);
        ctl_mode = 1;
        drv1(16'h3333, 16'h0000, 1'b1, 1'b0, c);
        check("timeout_latency", 32'(c), TIMEOUT + 2);
        check("timeout_err", 32'(err), 1);
        ctl_mode = 0;
        drv0(16'h4444, c);
        check("after_timeout_latency", 32'(c >= 3 && c <= 7), 1);

        // Stray completion and controller error both set err.
        do_reset();
        c_done = 1'b1;
        @(posedge clk);
        #1 c_done = 1'b0;
        check("stray_done_err", 32'(err), 1);
        do_reset();
        c_err = 1'b1;
        @(posedge clk);
        #1 c_err = 1'b0;
        check("c_err_err", 32'(err), 1);

        // Reset in the middle of WAIT.
        do_reset();
        ctl_mode = 2;
        r0_addr = 16'h5555;
        r0_rd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midwait_addr", 32'(c_addr), 32'h5555);
        #2 rst = 1'b0;
        #1;
        check("midwait_rst_addr", 32'(c_addr), 0);
        check("midwait_rst_op", 32'({c_rd, c_wr}), 0);
        check("midwait_rst_done", 32'({r0_done, r1_done}), 0);
        check("midwait_rst_stall", 32'(r0_stall), 0);
        check("midwait_rst_err", 32'(err), 0);
        ctl_mode = 0;
        do_reset();
        drv0(16'h6666, c);
        check("post_reset_latency", 32'(c >= 3 && c <= 7), 1);
        repeat (3) @(posedge clk);
        #1;
        check("final_cmp_empty", 32'(cmp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
